// File: rtl/tbird_input_conditioner.sv
// Input conditioner for the T-bird turn-signal FSM: synchronize, debounce, latch
// the hazard button and present LEFT/RIGHT/HAZ once per step period.

module tbird_db_chan #(
   parameter int DB_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic deb,
   output logic rise
);
   localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic          flip;

   assign flip = (sync[1] != deb) && (cnt == CW'(DB_CYCLES - 1));
   assign rise = flip & sync[1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync <= '0;
         deb  <= 1'b0;
         cnt  <= '0;
      end else begin
         sync <= {sync[0], raw};
         if (sync[1] == deb) begin
            cnt <= '0;
         end else if (flip) begin
            deb <= sync[1];
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

module tbird_input_conditioner #(
   parameter int DB_CYCLES = 4,
   parameter int TICK_DIV  = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic left_raw,
   input  logic right_raw,
   input  logic haz_btn,
   output logic LEFT,
   output logic RIGHT,
   output logic HAZ,
   output logic step
);
   localparam int NUM_CH = 3;
   localparam int TW     = $clog2(TICK_DIV);

   logic [NUM_CH-1:0] raw;
   logic [NUM_CH-1:0] deb;
   logic [NUM_CH-1:0] rise;
   logic              unused_rise;
   logic [TW-1:0]     tick;
   logic              wrap;
   logic              haz_lat;

   // channel 0 = left, 1 = right, 2 = hazard button
   assign raw = {haz_btn, right_raw, left_raw};

   generate
      for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
         tbird_db_chan #(.DB_CYCLES(DB_CYCLES)) u_chan (
            .clk  (clk),
            .reset(reset),
            .raw  (raw[g]),
            .deb  (deb[g]),
            .rise (rise[g])
         );
      end
   endgenerate

   assign unused_rise = ^rise[1:0];
   assign wrap        = (tick == TW'(TICK_DIV - 1));

   // Outputs sample the pre-edge debounced/latch values, so a flip landing on a
   // load edge is only seen at the following step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick    <= '0;
         step    <= 1'b0;
         haz_lat <= 1'b0;
         LEFT    <= 1'b0;
         RIGHT   <= 1'b0;
         HAZ     <= 1'b0;
      end else begin
         tick <= wrap ? '0 : tick + 1'b1;
         step <= wrap;
         if (wrap) begin
            LEFT  <= deb[0];
            RIGHT <= deb[1];
            HAZ   <= haz_lat;
         end
         if (rise[2]) haz_lat <= ~haz_lat;
      end
   end
endmodule

// File: tb/tb_tbird_input_conditioner.sv
// Randomized + directed bench for tbird_input_conditioner against a sliding-window
// model of the raw sample history.

module tb_tbird_input_conditioner;
   localparam int DB = 4;
   localparam int TD = 8;

   logic clk = 1'b0;
   logic reset, left_raw, right_raw, haz_btn;
   logic LEFT, RIGHT, HAZ, step;

   int vecs = 0;
   int miss = 0;

   // model state: edges since reset release, raw samples taken at each edge
   int         n;
   logic [2:0] hist[$];
   logic [2:0] m_deb;
   logic       m_hazl;
   logic [3:0] m_out;   // {step,HAZ,RIGHT,LEFT}

   tbird_input_conditioner #(.DB_CYCLES(DB), .TICK_DIV(TD)) dut (
      .clk      (clk),
      .reset    (reset),
      .left_raw (left_raw),
      .right_raw(right_raw),
      .haz_btn  (haz_btn),
      .LEFT     (LEFT),
      .RIGHT    (RIGHT),
      .HAZ      (HAZ),
      .step     (step)
   );

   always #5 clk = ~clk;

   function automatic logic samp(int k, int ch);
      if (k < 1 || k > hist.size()) return 1'b0;
      return hist[k-1][ch];
   endfunction

   function automatic void model_clear();
      n = 0;
      hist.delete();
      m_deb  = '0;
      m_hazl = 1'b0;
      m_out  = '0;
   endfunction

   // Synced value seen at edge j is the raw sample from edge j-2. The debounced
   // state flips at edge n when the last DB synced values all differ from it.
   function automatic void model_edge();
      logic [2:0] old_deb;
      logic       old_hazl;
      logic [2:0] flip;
      old_deb  = m_deb;
      old_hazl = m_hazl;
      n++;
      hist.push_back({haz_btn, right_raw, left_raw});
      for (int ch = 0; ch < 3; ch++) begin
         flip[ch] = (n >= DB);
         for (int j = n - DB + 1; j <= n; j++)
            if (samp(j - 2, ch) == old_deb[ch]) flip[ch] = 1'b0;
      end
      if (n % TD == 0) m_out = {1'b1, old_hazl, old_deb[1], old_deb[0]};
      else             m_out[3] = 1'b0;
      if (flip[2] && !old_deb[2]) m_hazl = ~old_hazl;
      m_deb = old_deb ^ flip;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      vecs++;
      if (got !== want) begin
         miss++;
         $display("FAIL %s: got %0h want %0h (edge %0d)", name, got, want, n);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      if (!reset) model_edge();
      #1;
      vecs++;
      if ({step, HAZ, RIGHT, LEFT} !== m_out) begin
         miss++;
         $display("FAIL model_cmp edge %0d {step,HAZ,RIGHT,LEFT}: got %b want %b",
                  n, {step, HAZ, RIGHT, LEFT}, m_out);
      end
   endtask

   task automatic do_reset(input int hold);
      reset = 1'b1;
      #1;
      chk("reset_async_zero", 32'({step, HAZ, RIGHT, LEFT}), 32'h0);
      model_clear();
      repeat (hold) cycle();
      reset = 1'b0;
   endtask

   task automatic align();
      for (int i = 0; i < TD && (n % TD) != 0; i++) cycle();
   endtask

   initial begin
      int  len;
      int  togg;
      logic prevh;
      logic seen;

      reset = 1'b1;
      {haz_btn, right_raw, left_raw} = 3'b000;
      model_clear();
      #3;
      chk("reset_state", 32'({step, HAZ, RIGHT, LEFT}), 32'h0);
      repeat (3) cycle();
      reset = 1'b0;

      // left held from edge 1: debounced at edge 6, LEFT loads at edge 8
      left_raw = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         cycle();
         if (k == 5) chk("model_deb_left_e5", 32'(m_deb[0]), 32'h0);
         if (k == 6) chk("model_deb_left_e6", 32'(m_deb[0]), 32'h1);
         if (k == 7) chk("left_e7", 32'({step, LEFT}), 32'h0);
         if (k == 8) chk("left_e8", 32'({step, LEFT}), 32'h3);
      end
      left_raw = 1'b0;
      repeat (16) cycle();
      chk("left_release", 32'(LEFT), 32'h0);

      // 3-cycle right glitch is rejected
      align();
      right_raw = 1'b1;
      repeat (3) cycle();
      right_raw = 1'b0;
      seen = 1'b0;
      repeat (50) begin
         cycle();
         if (RIGHT) seen = 1'b1;
      end
      chk("right_glitch", 32'(seen), 32'h0);

      // 6-cycle right pulse starting right after a load edge
      align();
      right_raw = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         if (k == 7) right_raw = 1'b0;
         cycle();
         if (k == 8)  chk("right_pulse_on", 32'(RIGHT), 32'h1);
         if (k == 16) chk("right_pulse_off", 32'(RIGHT), 32'h0);
      end

      // two hazard presses, 12 cycles each, 20 cycles released
      align();
      for (int k = 1; k <= 64; k++) begin
         haz_btn = ((k >= 1 && k <= 12) || (k >= 33 && k <= 44));
         cycle();
         if (k == 7)  chk("haz_press1_early", 32'(HAZ), 32'h0);
         if (k == 8)  chk("haz_press1", 32'(HAZ), 32'h1);
         if (k == 32) chk("haz_release1", 32'(HAZ), 32'h1);
         if (k == 39) chk("haz_press2_early", 32'(HAZ), 32'h1);
         if (k == 40) chk("haz_press2", 32'(HAZ), 32'h0);
         if (k == 64) chk("haz_release2", 32'(HAZ), 32'h0);
      end
      haz_btn = 1'b0;

      // left and right raised together
      align();
      left_raw  = 1'b1;
      right_raw = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         cycle();
         if (k == 7) chk("lr_same_e7", 32'({RIGHT, LEFT}), 32'h0);
         if (k == 8) chk("lr_same_e8", 32'({RIGHT, LEFT}), 32'h3);
      end

      // bouncing hazard press gives exactly one toggle
      togg  = 0;
      prevh = HAZ;
      for (int k = 1; k <= 40; k++) begin
         haz_btn = (k == 1 || k == 3 || (k >= 5 && k <= 18));
         cycle();
         if (HAZ !== prevh) togg++;
         prevh = HAZ;
      end
      chk("haz_bounce_toggles", 32'(togg), 32'h1);
      haz_btn = 1'b0;

      // reset mid-run with everything high, then step cadence
      align();
      chk("pre_reset_all_ones", 32'({step, HAZ, RIGHT, LEFT}), 32'hF);
      do_reset(2);
      for (int k = 1; k <= 100; k++) begin
         cycle();
         chk("step_cadence", 32'(step), 32'((k % TD) == 0));
      end
      {haz_btn, right_raw, left_raw} = 3'b000;
      repeat (16) cycle();

      // random segments of held values and short glitches, occasional reset
      for (int seg = 0; seg < 250; seg++) begin
         len = $urandom_range(1, 12);
         {haz_btn, right_raw, left_raw} = 3'($urandom);
         if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 3));
         repeat (len) cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule

// File: doc/tbird_input_conditioner.md
TBIRD_INPUT_CONDITIONER -- requirements
Module: tbird_input_conditioner

Interface
REQ-001 SHALL have parameter: DB_CYCLES, 4, consecutive stable clk cycles required to accept an input change (legal range >= 1).
REQ-002 SHALL have parameter: TICK_DIV, 8, clk cycles per step period (legal range >= 2).
REQ-003 SHALL have port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: left_raw  input  1  raw left turn switch, asynchronous to clk, may bounce.
REQ-006 SHALL have port: right_raw  input  1  raw right turn switch, asynchronous to clk, may bounce.
REQ-007 SHALL have port: haz_btn  input  1  raw momentary hazard push-button, asynchronous, may bounce.
REQ-008 SHALL have port: LEFT  output  1  conditioned left request to the turn-signal FSM.
REQ-009 SHALL have port: RIGHT  output  1  conditioned right request to the turn-signal FSM.
REQ-010 SHALL have port: HAZ  output  1  conditioned hazard mode to the turn-signal FSM.
REQ-011 SHALL have port: step  output  1  one-cycle pulse marking each step period boundary.

Function
REQ-012 Each raw input SHALL pass through a two-flop synchronizer before any other logic uses it.
REQ-013 Each channel SHALL have a debounced state register and a counter sized to hold DB_CYCLES-1.
REQ-014 Debounce rule per edge: synced == debounced -> counter cleared; synced != debounced and counter < DB_CYCLES-1 -> counter increments; synced != debounced and counter == DB_CYCLES-1 -> debounced takes synced value, counter cleared.
REQ-015 A raw change held steady SHALL appear on the debounced state at rising edge DB_CYCLES+2, the first edge sampling the new raw value being edge 1.
REQ-016 A raw pulse or glitch shorter than DB_CYCLES synchronized cycles SHALL leave the debounced state unchanged.
REQ-017 Hazard latch SHALL toggle on the edge where the debounced haz_btn changes 0->1; the debounced 1->0 change SHALL have no effect.
REQ-018 Tick counter SHALL count 0..TICK_DIV-1 and wrap to 0; at the edge where it equals TICK_DIV-1, step SHALL be registered high, else low.
REQ-019 step SHALL be high exactly one clk cycle in every TICK_DIV cycles; first high cycle follows the TICK_DIV-th rising edge after reset deassertion.
REQ-020 LEFT, RIGHT, HAZ SHALL be registers loaded only on the edge that raises step, with debounced left, debounced right and hazard latch; otherwise they hold.
REQ-021 On a load edge that coincides with a debounce flip or hazard toggle, outputs SHALL load the values held before that edge; the change appears at the next step.
REQ-022 LEFT and RIGHT SHALL be passed independently; simultaneous LEFT=RIGHT=1 is legal (downstream resolves it).
REQ-023 Input-to-output latency SHALL be DB_CYCLES+2 edges to debounced state plus 1..TICK_DIV edges to next load edge.

Reset
REQ-024 While reset is high, all synchronizer flops, debounced states, debounce counters, hazard latch, tick counter, step, LEFT, RIGHT, HAZ SHALL be 0, taking effect immediately without a clk edge.
REQ-025 Reset asserted mid-operation SHALL abort any partial debounce count and clear hazard latch; after release, operation restarts per REQ-019.

Verification (DB_CYCLES=4, TICK_DIV=8)
REQ-026 Reset pulse mid-run with all outputs 1 -> LEFT=RIGHT=HAZ=step=0 before next clk edge; step first high after edge 8 post-release, then every 8 cycles for 100 cycles.
REQ-027 left_raw 0->1 held, first sampled at edge 1 -> debounced left 1 at edge 6; LEFT=1 at first step-raising edge after edge 6, not earlier.
REQ-028 right_raw high for 3 cycles then low -> RIGHT stays 0 for 50 cycles; high for 6 cycles -> RIGHT 1 on next step, back to 0 on a later step.
REQ-029 haz_btn press held 12 cycles, released, repeated -> HAZ 0->1 on step after first press, 1->0 on step after second press; releases alone change nothing.
REQ-030 left_raw and right_raw raised same cycle -> LEFT and RIGHT both 1 on the same step edge; haz_btn bouncing 1-0-1 at 1-cycle intervals before settling high -> exactly one HAZ toggle.
